// File: rtl/axi_pkg.sv
// Shared AXI response codes and FSM state types
// for the AXI RAM subordinate.
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  function automatic int lane_bits(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 channel bundle (INCR-only subset) with
// subordinate and manager views.
interface axi_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic [USER_WIDTH-1:0]   wuser;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic [USER_WIDTH-1:0]   buser;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rlast;
  logic [USER_WIDTH-1:0]   ruser;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awlen, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bresp, buser, bvalid,
    input  bready,
    input  araddr, arlen, arvalid,
    output arready,
    output rdata, rlast, ruser, rresp, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awlen, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bresp, buser, bvalid,
    output bready,
    output araddr, arlen, arvalid,
    input  arready,
    input  rdata, rlast, ruser, rresp, rvalid,
    output rready
  );

endinterface

// File: rtl/axi_ram_slave_sdp_ram.sv
// Simple dual-port RAM: byte-enabled write port,
// registered read port with enable, read-first.
module sdp_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW/8-1:0] wbe,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DW / 8; i++) begin
        if (wbe[i]) begin
          mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 INCR-burst RAM subordinate with independent
// read and write engines sharing one dual-port RAM.
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1
) (
  input logic  clk,
  input logic  rst,
  axi_if.slave s_axi
);

  localparam int OFF = lane_bits(DATA_WIDTH);
  localparam int IW  = ADDR_WIDTH - OFF;
  localparam int SW  = DATA_WIDTH / 8;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [IW-1:0] w_idx;
  logic [7:0]    w_cnt;
  logic [7:0]    w_len;
  logic          w_err;

  logic [IW-1:0] r_idx;
  logic [7:0]    r_cnt;
  logic [7:0]    r_len;

  logic aw_hs, w_hs, b_hs;
  logic ar_hs, r_hs;
  logic w_final, r_final;

  logic          ram_re;
  logic [IW-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_q;

  logic unused;
  assign unused = ^{s_axi.wuser,
                    s_axi.awaddr[OFF-1:0],
                    s_axi.araddr[OFF-1:0]};

  assign aw_hs   = s_axi.awvalid && s_axi.awready;
  assign w_hs    = s_axi.wvalid && s_axi.wready;
  assign b_hs    = s_axi.bvalid && s_axi.bready;
  assign ar_hs   = s_axi.arvalid && s_axi.arready;
  assign r_hs    = s_axi.rvalid && s_axi.rready;
  assign w_final = (w_cnt == w_len);
  assign r_final = (r_cnt == r_len);

  // ---------------- write engine ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_next;
    end
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: if (aw_hs) w_next = W_DATA;
      W_DATA: if (w_hs && w_final) w_next = W_RESP;
      W_RESP: if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi.awready = (w_state == W_IDLE);
    s_axi.wready  = (w_state == W_DATA);
    s_axi.bvalid  = (w_state == W_RESP);
    s_axi.buser   = '0;
    s_axi.bresp   = AXI_RESP_OKAY;
    if (w_state == W_RESP && w_err) begin
      s_axi.bresp = AXI_RESP_SLVERR;
    end
  end

  // The beat counter ends the burst; wlast only flags an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_idx <= '0;
      w_cnt <= '0;
      w_len <= '0;
      w_err <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_idx <= s_axi.awaddr[ADDR_WIDTH-1:OFF];
        w_cnt <= '0;
        w_len <= s_axi.awlen;
        w_err <= 1'b0;
      end
      if (w_hs) begin
        w_idx <= w_idx + IW'(1);
        w_cnt <= w_cnt + 8'd1;
        if (s_axi.wlast != w_final) begin
          w_err <= 1'b1;
        end
      end
      if (b_hs) begin
        w_err <= 1'b0;
      end
    end
  end

  // ---------------- read engine ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_next;
    end
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_next = R_DATA;
      R_DATA: if (r_hs && r_final) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready = (r_state == R_IDLE);
    s_axi.rvalid  = (r_state == R_DATA);
    s_axi.rlast   = (r_state == R_DATA) && r_final;
    s_axi.rresp   = AXI_RESP_OKAY;
    s_axi.ruser   = '0;
    s_axi.rdata   = '0;
    if (r_state == R_DATA) begin
      s_axi.rdata = ram_q;
    end
  end

  // RAM output only advances on a handshake, so a stalled
  // beat holds even if the same word is written meanwhile.
  always_comb begin
    ram_re    = ar_hs || r_hs;
    ram_raddr = r_idx + IW'(1);
    if (ar_hs) begin
      ram_raddr = s_axi.araddr[ADDR_WIDTH-1:OFF];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_cnt <= '0;
      r_len <= '0;
    end else begin
      if (ar_hs) begin
        r_idx <= s_axi.araddr[ADDR_WIDTH-1:OFF];
        r_cnt <= '0;
        r_len <= s_axi.arlen;
      end else if (r_hs) begin
        r_idx <= r_idx + IW'(1);
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  sdp_ram #(
    .AW (IW),
    .DW (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_hs),
    .waddr (w_idx),
    .wbe   (s_axi.wstrb[SW-1:0]),
    .wdata (s_axi.wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed self-checking bench for axi_ram_slave
// (32-bit data, 1 KiB address space, 256 words).
module tb_axi_ram_slave;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int UW = 1;

  typedef logic [31:0] vec_t [8];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  axi_if #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW)
  ) bus ();

  axi_ram_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input string tag,
                             input logic [AW-1:0] a,
                             input logic [7:0] len,
                             input vec_t d,
                             input logic [3:0] strb,
                             input logic [7:0] wl,
                             input bit bp,
                             input logic [1:0] exp_resp);
    int n;
    bus.awaddr  = a;
    bus.awlen   = len;
    bus.awvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_awready"}, bus.awready, 1);
    tick();
    bus.awvalid = 1'b0;
    check({tag, "_wready"}, bus.wready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata  = d[i];
      bus.wstrb  = strb;
      bus.wlast  = wl[i];
      bus.wvalid = 1'b1;
      n = 0;
      while (bus.wready !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      tick();
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_bvalid"}, bus.bvalid, 1);
    check({tag, "_bresp"}, bus.bresp, exp_resp);
    check({tag, "_buser"}, bus.buser, 0);
    if (bp) begin
      repeat ($urandom_range(1, 3)) begin
        bus.bready = 1'b0;
        tick();
        check({tag, "_bvalid_hold"}, bus.bvalid, 1);
        check({tag, "_bresp_hold"}, bus.bresp, exp_resp);
      end
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check({tag, "_bvalid_clr"}, bus.bvalid, 0);
    check({tag, "_awready_back"}, bus.awready, 1);
  endtask

  task automatic read_burst(input string tag,
                            input logic [AW-1:0] a,
                            input logic [7:0] len,
                            input vec_t e,
                            input bit bp);
    int n;
    bus.araddr  = a;
    bus.arlen   = len;
    bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_arready"}, bus.arready, 1);
    bus.rready = !bp;
    tick();
    bus.arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      check({tag, "_rvalid"}, bus.rvalid, 1);
      check({tag, "_rdata"}, bus.rdata, e[i]);
      check({tag, "_rlast"}, bus.rlast, (i == int'(len)));
      check({tag, "_rresp"}, bus.rresp, 0);
      if (bp) begin
        repeat ($urandom_range(0, 2)) begin
          bus.rready = 1'b0;
          tick();
          check({tag, "_rvalid_hold"}, bus.rvalid, 1);
          check({tag, "_rdata_hold"}, bus.rdata, e[i]);
          check({tag, "_rlast_hold"}, bus.rlast,
                (i == int'(len)));
        end
      end
      bus.rready = 1'b1;
      tick();
      if (bp) bus.rready = 1'b0;
    end
    bus.rready = 1'b0;
    check({tag, "_rvalid_end"}, bus.rvalid, 0);
    check({tag, "_arready_end"}, bus.arready, 1);
  endtask

  vec_t d, e;

  initial begin
    bus.awaddr  = '0;
    bus.awlen   = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wlast   = 1'b0;
    bus.wuser   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0;
    bus.arlen   = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    check("rst_awready", bus.awready, 1);
    check("rst_arready", bus.arready, 1);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rlast", bus.rlast, 0);
    check("rst_bresp", bus.bresp, 0);
    check("rst_rresp", bus.rresp, 0);
    check("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    tick();

    // single beat
    d = '{32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0};
    write_burst("single_w", 10'h010, 8'd0, d,
                4'hF, 8'h01, 1'b0, 2'b00);
    read_burst("single_r", 10'h010, 8'd0, d, 1'b0);

    // burst wrapping from word 254 to word 1
    d = '{32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 0, 0};
    write_burst("wrap_w", 10'h3F8, 8'd3, d,
                4'hF, 8'h08, 1'b0, 2'b00);
    read_burst("wrap_r", 10'h3F8, 8'd3, d, 1'b0);
    e = '{32'd3, 32'd4, 0, 0, 0, 0, 0, 0};
    read_burst("wrap_r0", 10'h000, 8'd1, e, 1'b0);
    e = '{32'd2, 0, 0, 0, 0, 0, 0, 0};
    read_burst("wrap_r255", 10'h3FE, 8'd0, e, 1'b0);

    // byte strobes
    d = '{32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0};
    write_burst("strb_w1", 10'h020, 8'd0, d,
                4'hF, 8'h01, 1'b0, 2'b00);
    d = '{32'h00000000, 0, 0, 0, 0, 0, 0, 0};
    write_burst("strb_w2", 10'h021, 8'd0, d,
                4'h5, 8'h01, 1'b0, 2'b00);
    e = '{32'hFF00FF00, 0, 0, 0, 0, 0, 0, 0};
    read_burst("strb_r", 10'h020, 8'd0, e, 1'b0);

    // early wlast: both beats land, SLVERR once
    d = '{32'hA1, 32'hA2, 0, 0, 0, 0, 0, 0};
    write_burst("early_w", 10'h040, 8'd1, d,
                4'hF, 8'h03, 1'b0, 2'b10);
    read_burst("early_r", 10'h040, 8'd1, d, 1'b0);
    d = '{32'hB1, 32'hB2, 0, 0, 0, 0, 0, 0};
    write_burst("clean_w", 10'h040, 8'd1, d,
                4'hF, 8'h02, 1'b0, 2'b00);
    // missing wlast on final beat
    d = '{32'hC1, 32'hC2, 0, 0, 0, 0, 0, 0};
    write_burst("late_w", 10'h060, 8'd1, d,
                4'hF, 8'h00, 1'b0, 2'b10);
    read_burst("late_r", 10'h060, 8'd1, d, 1'b0);

    // 8-beat bursts with random backpressure
    d = '{32'h11111111, 32'h22222222,
          32'h33333333, 32'h44444444,
          32'h55555555, 32'h66666666,
          32'h77777777, 32'h88888888};
    write_burst("bp_w", 10'h100, 8'd7, d,
                4'hF, 8'h80, 1'b1, 2'b00);
    read_burst("bp_r1", 10'h100, 8'd7, d, 1'b1);
    read_burst("bp_r2", 10'h100, 8'd7, d, 1'b1);

    // reset after two of four read beats
    bus.araddr  = 10'h3F8;
    bus.arlen   = 8'd3;
    bus.arvalid = 1'b1;
    check("rrst_arready", bus.arready, 1);
    tick();
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    check("rrst_beat0", bus.rdata, 32'd1);
    tick();
    check("rrst_beat1", bus.rdata, 32'd2);
    tick();
    rst = 1'b1;
    bus.rready = 1'b0;
    tick();
    rst = 1'b0;
    check("rrst_rvalid", bus.rvalid, 0);
    check("rrst_rlast", bus.rlast, 0);
    check("rrst_rdata", bus.rdata, 0);
    check("rrst_arready", bus.arready, 1);
    check("rrst_awready", bus.awready, 1);
    tick();
    check("rrst_rvalid2", bus.rvalid, 0);
    e = '{32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0};
    read_burst("rrst_keep", 10'h010, 8'd0, e, 1'b0);

    // reset after two of four write beats
    bus.awaddr  = 10'h080;
    bus.awlen   = 8'd3;
    bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.wstrb   = 4'hF;
    bus.wvalid  = 1'b1;
    bus.wdata   = 32'h5A5A0001;
    tick();
    bus.wdata   = 32'h5A5A0002;
    tick();
    rst = 1'b1;
    bus.wvalid = 1'b0;
    tick();
    rst = 1'b0;
    check("wrst_wready", bus.wready, 0);
    check("wrst_bvalid", bus.bvalid, 0);
    check("wrst_awready", bus.awready, 1);
    tick();
    check("wrst_bvalid2", bus.bvalid, 0);
    e = '{32'h5A5A0001, 32'h5A5A0002, 0, 0, 0, 0, 0, 0};
    read_burst("wrst_keep", 10'h080, 8'd1, e, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
